// File: rtl/eth_pkg.sv
// Shared Ethernet II types and constants for the TX arbiter slice.
// Provides MAC/EtherType typedefs, common EtherTypes and the arbiter FSM enum.
package eth_pkg;

  typedef logic [47:0] mac_addr_t;
  typedef logic [15:0] eth_type_t;

  localparam eth_type_t ETH_TYPE_IPV4 = 16'h0800;
  localparam eth_type_t ETH_TYPE_ARP  = 16'h0806;

  typedef enum logic {
    IDLE,
    PKT
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational N-way picker: one-hot winner from a request vector.
// Ports: req (requests), last (previous winner index), win (one-hot winner).
// ETH_ARB_STRICT_PRIO_EN selects fixed lowest-index priority instead of
// round-robin starting after last.
module rr_pick #(
  parameter  int N  = 4,
  localparam int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  win
);

`ifdef ETH_ARB_STRICT_PRIO_EN

  logic found;
  logic unused_last;

  assign unused_last = ^last;

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

`else

  logic          found;
  logic [LW-1:0] idx;

  // Walk last+1 .. last+N (mod N); first set request wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = LW'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/eth_ii_tx_arbiter.sv
// Round-robin arbiter sharing one Ethernet II packer between N_PORTS
// requesters; header and payload of the granted port pass straight through.
// Ports: clk/reset, per-port req_mac_* header and req_t* payload buses,
// hdr_mac_* / user_t* to the packer, grant_o (one-hot) and busy_o status.
// Build option: ETH_ARB_STRICT_PRIO_EN (fixed priority, lowest index wins).
module eth_ii_tx_arbiter
  import eth_pkg::*;
#(
  parameter  int N_PORTS = 4,
  parameter  int DATA_W  = 32,
  localparam int KEEP_W  = DATA_W / 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_PORTS*48-1:0]  req_mac_dest_i,
  input  logic [N_PORTS*48-1:0]  req_mac_src_i,
  input  logic [N_PORTS*16-1:0]  req_mac_type_i,
  input  logic [N_PORTS-1:0]     req_mac_vld_i,
  output logic [N_PORTS-1:0]     req_mac_rdy_o,
  input  logic [N_PORTS*DATA_W-1:0] req_tdata_i,
  input  logic [N_PORTS*KEEP_W-1:0] req_tkeep_i,
  input  logic [N_PORTS-1:0]     req_tvld_i,
  input  logic [N_PORTS-1:0]     req_tlast_i,
  output logic [N_PORTS-1:0]     req_trdy_o,
  output mac_addr_t              hdr_mac_dest_o,
  output mac_addr_t              hdr_mac_src_o,
  output eth_type_t              hdr_mac_type_o,
  output logic                   hdr_mac_vld_o,
  input  logic                   hdr_mac_rdy_i,
  output logic [DATA_W-1:0]      user_tdata_o,
  output logic [KEEP_W-1:0]      user_tkeep_o,
  output logic                   user_tvld_o,
  output logic                   user_tlast_o,
  input  logic                   user_trdy_i,
  output logic [N_PORTS-1:0]     grant_o,
  output logic                   busy_o
);

  localparam int LW = $clog2(N_PORTS);

  arb_state_t         state, state_nx;
  logic [N_PORTS-1:0] grant, win;
  logic [LW-1:0]      gidx, last_winner, win_idx;
  logic               hdr_done, last_done;
  logic               hs_hdr, hs_last, rel_pkt, pkt;

  rr_pick #(.N(N_PORTS)) u_pick (
    .req  (req_mac_vld_i),
    .last (last_winner),
    .win  (win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (win[i]) win_idx = LW'(i);
    end
  end

  // Outputs are forced to zero outside PKT so reset clears them at once.
  always_comb begin
    pkt            = (state == PKT);
    hdr_mac_dest_o = '0;
    hdr_mac_src_o  = '0;
    hdr_mac_type_o = '0;
    hdr_mac_vld_o  = 1'b0;
    user_tdata_o   = '0;
    user_tkeep_o   = '0;
    user_tvld_o    = 1'b0;
    user_tlast_o   = 1'b0;
    req_mac_rdy_o  = '0;
    req_trdy_o     = '0;
    if (pkt) begin
      hdr_mac_dest_o = req_mac_dest_i[int'(gidx)*48 +: 48];
      hdr_mac_src_o  = req_mac_src_i[int'(gidx)*48 +: 48];
      hdr_mac_type_o = req_mac_type_i[int'(gidx)*16 +: 16];
      hdr_mac_vld_o  = req_mac_vld_i[gidx] & ~hdr_done;
      user_tdata_o   = req_tdata_i[int'(gidx)*DATA_W +: DATA_W];
      user_tkeep_o   = req_tkeep_i[int'(gidx)*KEEP_W +: KEEP_W];
      user_tvld_o    = req_tvld_i[gidx] & ~last_done;
      user_tlast_o   = req_tlast_i[gidx];
      req_mac_rdy_o  = grant & {N_PORTS{hdr_mac_rdy_i & ~hdr_done}};
      req_trdy_o     = grant & {N_PORTS{user_trdy_i & ~last_done}};
    end
  end

  assign hs_hdr  = hdr_mac_vld_o & hdr_mac_rdy_i;
  assign hs_last = user_tvld_o & user_trdy_i & user_tlast_o;
  // Release counts handshakes landing in this same cycle.
  assign rel_pkt = pkt & (hdr_done | hs_hdr) & (last_done | hs_last);

  assign grant_o = grant;
  assign busy_o  = pkt;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (|req_mac_vld_i) state_nx = PKT;
      PKT:  if (rel_pkt)        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      gidx        <= '0;
      last_winner <= LW'(N_PORTS - 1);
      hdr_done    <= 1'b0;
      last_done   <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (|req_mac_vld_i) begin
            grant       <= win;
            gidx        <= win_idx;
            last_winner <= win_idx;
            hdr_done    <= 1'b0;
            last_done   <= 1'b0;
          end
        end
        PKT: begin
          if (rel_pkt) begin
            grant <= '0;
          end else begin
            if (hs_hdr)  hdr_done  <= 1'b1;
            if (hs_last) last_done <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
